// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: streams a little-endian message from dpsram port A as big-endian
// 32-bit words, then appends the 0x80 marker, zero fill and the 64-bit bit-length field.
module sha1_msg_padder #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       message_size,
  output logic              busy,
  output logic              done,
  output logic              port_A_clk,
  output logic              port_A_we,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out,
  output logic [31:0]       word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [3:0]        word_idx,
  output logic              block_last
);

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StEmit, StDone} state_e;

  state_e            state_q, state_d;
  logic [31:0]       g_q, g_d;
  logic [31:0]       size_q, size_d;
  logic [31:0]       last_g_q, last_g_d;        // TOT-1
  logic [31:0]       blk_start_q, blk_start_d;  // TOT-16, first word of the final block
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic              valid_q, valid_d;
  logic [3:0]        idx_q, idx_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [32:0] n_blk, tot;
  logic [31:0] full;
  logic [1:0]  rem;
  logic        needs_mem;
  logic [31:0] swapped, mem_word, pad_word;
  logic        unused_bits;

  // Block count from the requested size; 33 bits so size+8 cannot overflow.
  assign n_blk = (({1'b0, message_size} + 33'd8) >> 6) + 33'd1;
  assign tot   = n_blk << 4;
  assign unused_bits = ^{message_addr[31:ADDR_W], tot[32]};

  assign full      = {2'b00, size_q[31:2]};
  assign rem       = size_q[1:0];
  assign needs_mem = (g_q < full) || ((g_q == full) && (rem != 2'd0));
  assign swapped   = {port_A_data_out[7:0], port_A_data_out[15:8],
                      port_A_data_out[23:16], port_A_data_out[31:24]};

  // Format a fetched memory word; the partial tail word gets the 0x80 marker after its bytes.
  always_comb begin
    mem_word = swapped;
    if (g_q == full) begin
      unique case (rem)
        2'd1:    mem_word = {swapped[31:24], 8'h80, 16'h0000};
        2'd2:    mem_word = {swapped[31:16], 8'h80, 8'h00};
        2'd3:    mem_word = {swapped[31:8], 8'h80};
        default: mem_word = swapped;
      endcase
    end
  end

  // Words that need no memory read: aligned marker, zero fill, length high/low halves.
  always_comb begin
    pad_word = 32'h0;
    if (g_q == full) begin
      pad_word = 32'h8000_0000;
    end else if (g_q == last_g_q) begin
      pad_word = {size_q[28:0], 3'b000};
    end else if (g_q == last_g_q - 32'd1) begin
      pad_word = {29'd0, size_q[31:29]};
    end
  end

  // Next-state and registered-output logic of the control FSM.
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    size_d      = size_q;
    last_g_d    = last_g_q;
    blk_start_d = blk_start_q;
    base_d      = base_q;
    addr_d      = addr_q;
    word_d      = word_q;
    valid_d     = valid_q;
    idx_d       = idx_q;
    last_d      = last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d      = message_addr[ADDR_W-1:0];
          size_d      = message_size;
          last_g_d    = tot[31:0] - 32'd1;
          blk_start_d = tot[31:0] - 32'd16;
          g_d         = 32'd0;
          busy_d      = 1'b1;
          state_d     = StFetch;
        end
      end
      StFetch: begin
        if (needs_mem) begin
          addr_d  = base_q + {g_q[ADDR_W-3:0], 2'b00};
          state_d = StWait;
        end else begin
          word_d  = pad_word;
          valid_d = 1'b1;
          idx_d   = g_q[3:0];
          last_d  = (g_q >= blk_start_q);
          state_d = StEmit;
        end
      end
      StWait: begin
        word_d  = mem_word;
        valid_d = 1'b1;
        idx_d   = g_q[3:0];
        last_d  = (g_q >= blk_start_q);
        state_d = StEmit;
      end
      StEmit: begin
        if (word_ready) begin
          valid_d = 1'b0;
          if (g_q == last_g_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            g_d     = g_q + 32'd1;
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      g_q         <= 32'd0;
      size_q      <= 32'd0;
      last_g_q    <= 32'd0;
      blk_start_q <= 32'd0;
      base_q      <= '0;
      addr_q      <= '0;
      word_q      <= 32'd0;
      valid_q     <= 1'b0;
      idx_q       <= 4'd0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      size_q      <= size_d;
      last_g_q    <= last_g_d;
      blk_start_q <= blk_start_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign port_A_clk     = clk;
  assign port_A_we      = 1'b0;
  assign port_A_data_in = 32'h0;
  assign port_A_addr    = addr_q;
  assign word_out       = word_q;
  assign word_valid     = valid_q;
  assign word_idx       = idx_q;
  assign block_last     = last_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Scoreboard bench for sha1_msg_padder: a byte-level padding model fills the expected queue,
// a monitor pops and compares each accepted word.
module tb_sha1_msg_padder;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   message_addr;
  logic [31:0]   message_size;
  logic          busy;
  logic          done;
  logic          port_A_clk;
  logic          port_A_we;
  logic [AW-1:0] port_A_addr;
  logic [31:0]   port_A_data_in;
  logic [31:0]   port_A_data_out;
  logic [31:0]   word_out;
  logic          word_valid;
  logic          word_ready;
  logic [3:0]    word_idx;
  logic          block_last;

  sha1_msg_padder #(.ADDR_W(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .message_addr    (message_addr),
    .message_size    (message_size),
    .busy            (busy),
    .done            (done),
    .port_A_clk      (port_A_clk),
    .port_A_we       (port_A_we),
    .port_A_addr     (port_A_addr),
    .port_A_data_in  (port_A_data_in),
    .port_A_data_out (port_A_data_out),
    .word_out        (word_out),
    .word_valid      (word_valid),
    .word_ready      (word_ready),
    .word_idx        (word_idx),
    .block_last      (block_last)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:(1 << (AW - 2)) - 1];
  assign port_A_data_out = mem[port_A_addr[AW-1:2]];

  typedef struct {
    logic [31:0] w;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   acc_cnt = 0;
  int   done_cnt = 0;
  int   ready_pct = 100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: build the padded byte stream, then slice it into big-endian words.
  task automatic push_expected(input int unsigned size, input logic [15:0] base,
                               output int unsigned nwords);
    byte unsigned b[$];
    logic [31:0]  w;
    logic [15:0]  a;
    logic [63:0]  bits;
    exp_t         e;
    for (int unsigned k = 0; k < size; k++) begin
      a = base + 16'(4 * (k / 4));
      w = mem[a[15:2]];
      b.push_back(w[8 * (k % 4) +: 8]);
    end
    b.push_back(8'h80);
    while ((b.size() % 64) != 56) b.push_back(8'h00);
    bits = 64'(size) * 64'd8;
    for (int i = 7; i >= 0; i--) b.push_back(bits[8 * i +: 8]);
    nwords = b.size() / 4;
    for (int unsigned i = 0; i < nwords; i++) begin
      e.w    = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
      e.idx  = 4'(i % 16);
      e.last = (i >= nwords - 16);
      exp_q.push_back(e);
    end
  endtask

  // Consumer ready, changed just after each active edge.
  always @(posedge clk) begin
    #1;
    word_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
  end

  always @(negedge clk) if (!reset && done) done_cnt++;

  // Monitor: compare accepted words and check stall stability.
  logic        stall = 1'b0;
  logic [31:0] prev_w;
  logic [3:0]  prev_idx;
  logic        prev_last;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stall = 1'b0;
    end else if (word_valid) begin
      if (stall) begin
        check("stall_word", 64'(word_out), 64'(prev_w));
        check("stall_idx", 64'(word_idx), 64'(prev_idx));
        check("stall_last", 64'(block_last), 64'(prev_last));
      end
      if (word_ready) begin
        stall = 1'b0;
        acc_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(word_out), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("word_out", 64'(word_out), 64'(e.w));
          check("word_idx", 64'(word_idx), 64'(e.idx));
          check("block_last", 64'(block_last), 64'(e.last));
        end
      end else begin
        stall     = 1'b1;
        prev_w    = word_out;
        prev_idx  = word_idx;
        prev_last = block_last;
      end
    end else if (stall) begin
      check("valid_dropped", 64'(word_valid), 64'd1);
      stall = 1'b0;
    end
  end

  task automatic run(input int unsigned size, input logic [15:0] base,
                     input bit chk_lat, input bit inject);
    int unsigned nwords, nmem, lat;
    int          n, d0;
    push_expected(size, base, nwords);
    nmem = (size + 3) / 4;
    lat  = 3 * nmem + 2 * (nwords - nmem);
    d0   = done_cnt;
    @(negedge clk);
    message_addr = {16'h0, base};
    message_size = size;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    n = 0;
    forever begin
      @(posedge clk);
      n++;
      if (start) #1 start = 1'b0;
      @(negedge clk);
      if (done) break;
      if (inject && n == 4) begin
        start = 1'b1;
        message_size = 32'd7;
        message_addr = 32'h1234;
      end
      if (n > 5000) begin
        check("done_timeout", 64'(n), 64'(lat));
        return;
      end
    end
    check("busy_at_done", 64'(busy), 64'd0);
    if (chk_lat) check("latency", 64'(n), 64'(lat));
    @(posedge clk);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("done_count", 64'(done_cnt - d0), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int unsigned nw;
    int          d0, n;
    for (int i = 0; i < (1 << (AW - 2)); i++) mem[i] = $urandom;
    mem[0]               = 32'h0063_6261;
    mem[16'h0400/4 + 13] = 32'hDDCC_BBAA;
    reset = 1'b1;
    start = 1'b0;
    message_addr = 32'h0;
    message_size = 32'h0;
    word_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(word_valid), 64'd0);
    check("rst_word", 64'(word_out), 64'd0);
    check("rst_idx", 64'(word_idx), 64'd0);
    check("rst_last", 64'(block_last), 64'd0);
    check("rst_addr", 64'(port_A_addr), 64'd0);
    check("we_const", 64'(port_A_we), 64'd0);
    check("din_const", 64'(port_A_data_in), 64'd0);
    reset = 1'b0;

    // Empty message first: any read would move the address off zero.
    run(0, 16'h0100, 1'b1, 1'b0);
    check("no_reads_size0", 64'(port_A_addr), 64'd0);
    run(3, 16'h0000, 1'b1, 1'b0);
    run(56, 16'h0200, 1'b1, 1'b0);
    run(55, 16'h0400, 1'b1, 1'b0);
    ready_pct = 40;
    run(120, 16'h0800, 1'b0, 1'b0);
    ready_pct = 100;

    // Abort mid-message after five words.
    push_expected(120, 16'h0800, nw);
    acc_cnt = 0;
    d0 = done_cnt;
    @(negedge clk);
    message_addr = 32'h0800;
    message_size = 32'd120;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (acc_cnt < 5 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("reach_g5", 64'(acc_cnt >= 5), 64'd1);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(word_valid), 64'd0);
    check("abort_word", 64'(word_out), 64'd0);
    check("abort_idx", 64'(word_idx), 64'd0);
    check("abort_last", 64'(block_last), 64'd0);
    check("abort_addr", 64'(port_A_addr), 64'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run(3, 16'h0000, 1'b1, 1'b1);

    // Random sizes and bases, including address wrap near the top of memory.
    ready_pct = 60;
    run(100, 16'hFFE0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      ready_pct = (i % 2 == 0) ? 100 : 50;
      run($urandom_range(200), 16'($urandom) & 16'hFFFC, ready_pct == 100, i == 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
